// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the async FIFO pointer blocks.
//   DEFAULT_WIDTH - default pointer width (including wrap bit)
//   depth()       - FIFO depth for a given pointer width
//   bin2gray()    - binary to reflected Gray code (up to 32 bits)
//   gray2bin()    - Gray code to binary (up to 32 bits, zero-extended input)
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int unsigned depth(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int unsigned i = 31; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// gray2bin: purely combinational Gray-to-binary converter.
//   gray - Gray-coded input, WIDTH bits
//   bin  - binary output, WIDTH bits
// Each binary bit is the XOR of all Gray bits at or above it (prefix chain
// running from the MSB down).
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = gray;
    for (int unsigned i = WIDTH - 1; i > 0; i--) begin
      bin[i-1] = bin[i] ^ gray[i-1];
    end
  end

endmodule

// File: rtl/wptr_full.sv
// wptr_full: write-domain pointer and full-flag logic for the dual-clock FIFO.
//   wclk         - write-domain clock
//   wrst_n       - asynchronous active-low reset
//   winc         - write request this cycle
//   wq2_rptr     - read Gray pointer, synchronised into wclk
//   waddr        - RAM write address (binary, WIDTH-1 bits)
//   wptr         - registered Gray write pointer to the read-side synchroniser
//   wfull        - FIFO full (registered)
//   walmost_full - fill >= AF_THRESH (registered)
//   wcount       - fill level seen from the write domain (registered)
//   wovf         - sticky overflow flag, present only with WFULL_OVERFLOW_EN
// Optional feature macro: WFULL_OVERFLOW_EN.
module wptr_full
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int AF_THRESH = 6
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [WIDTH-1:0] wq2_rptr,
  output logic [WIDTH-2:0] waddr,
  output logic [WIDTH-1:0] wptr,
  output logic             wfull,
  output logic             walmost_full,
  output logic [WIDTH-1:0] wcount
`ifdef WFULL_OVERFLOW_EN
  ,
  output logic             wovf
`endif
);

  localparam logic [WIDTH-1:0] AF_T = AF_THRESH[WIDTH-1:0];

  logic [WIDTH-1:0] wbin;
  logic [WIDTH-1:0] wbin_next;
  logic [WIDTH-1:0] wgray_next;
  logic [WIDTH-1:0] rbin;
  logic [WIDTH-1:0] fill_next;
  logic             wfull_val;

  gray2bin #(.WIDTH(WIDTH)) u_rbin (
    .gray (wq2_rptr),
    .bin  (rbin)
  );

  always_comb begin
    wbin_next  = wbin + {{(WIDTH-1){1'b0}}, winc & ~wfull};
    wgray_next = WIDTH'(bin2gray(32'(wbin_next)));
    // Full when the write pointer has lapped the read pointer exactly once:
    // top two Gray bits inverted, the rest equal.
    wfull_val  = (wgray_next == {~wq2_rptr[WIDTH-1:WIDTH-2], wq2_rptr[WIDTH-3:0]});
    fill_next  = wbin_next - rbin;
  end

  assign waddr = wbin[WIDTH-2:0];

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wcount       <= '0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= wfull_val;
      walmost_full <= (fill_next >= AF_T);
      wcount       <= fill_next;
    end
  end

`ifdef WFULL_OVERFLOW_EN
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wovf <= 1'b0;
    end else if (winc && wfull) begin
      wovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wptr_full.sv
module tb_wptr_full;

  logic       wclk;
  logic       wrst_n;
  logic       winc;
  logic [3:0] wq2_rptr;
  logic [2:0] waddr;
  logic [3:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [3:0] wcount;
`ifdef WFULL_OVERFLOW_EN
  logic       wovf;
`endif

  wptr_full #(.WIDTH(4), .AF_THRESH(6)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wcount       (wcount)
`ifdef WFULL_OVERFLOW_EN
    ,
    .wovf         (wovf)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic w, input logic [3:0] r);
    @(negedge wclk);
    winc     = w;
    wq2_rptr = r;
    @(posedge wclk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".waddr"}, int'(waddr), 0);
    check({tag, ".wptr"}, int'(wptr), 0);
    check({tag, ".wfull"}, int'(wfull), 0);
    check({tag, ".walmost_full"}, int'(walmost_full), 0);
    check({tag, ".wcount"}, int'(wcount), 0);
`ifdef WFULL_OVERFLOW_EN
    check({tag, ".wovf"}, int'(wovf), 0);
`endif
  endtask

  // Mid-cycle asynchronous reset pulse, released at a falling edge.
  task automatic do_reset(input string tag);
    @(negedge wclk);
    winc = 1'b0;
    #2;
    wrst_n = 1'b0;
    #1;
    check_all_zero(tag);
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  function automatic logic [3:0] gray(input int k);
    int m;
    m = k % 16;
    return 4'(m ^ (m >> 1));
  endfunction

  typedef struct {
    logic       winc;
    logic [3:0] rptr;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       full;
    logic       af;
    logic [3:0] cnt;
  } vec_t;

  vec_t vec[12];

  initial begin
    // Fill from empty, write while full, drain one, refill.
    vec[0]  = '{1'b1, 4'b0000, 3'd1, 4'b0001, 1'b0, 1'b0, 4'd1};
    vec[1]  = '{1'b1, 4'b0000, 3'd2, 4'b0011, 1'b0, 1'b0, 4'd2};
    vec[2]  = '{1'b1, 4'b0000, 3'd3, 4'b0010, 1'b0, 1'b0, 4'd3};
    vec[3]  = '{1'b1, 4'b0000, 3'd4, 4'b0110, 1'b0, 1'b0, 4'd4};
    vec[4]  = '{1'b1, 4'b0000, 3'd5, 4'b0111, 1'b0, 1'b0, 4'd5};
    vec[5]  = '{1'b1, 4'b0000, 3'd6, 4'b0101, 1'b0, 1'b1, 4'd6};
    vec[6]  = '{1'b1, 4'b0000, 3'd7, 4'b0100, 1'b0, 1'b1, 4'd7};
    vec[7]  = '{1'b1, 4'b0000, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8};
    vec[8]  = '{1'b1, 4'b0000, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8};
    vec[9]  = '{1'b0, 4'b0001, 3'd0, 4'b1100, 1'b0, 1'b1, 4'd7};
    vec[10] = '{1'b1, 4'b0001, 3'd1, 4'b1101, 1'b1, 1'b1, 4'd8};
    vec[11] = '{1'b0, 4'b0001, 3'd1, 4'b1101, 1'b1, 1'b1, 4'd8};

    wrst_n   = 1'b0;
    winc     = 1'b0;
    wq2_rptr = 4'b0000;
    #12;
    check_all_zero("por");
    @(negedge wclk);
    wrst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      apply(vec[i].winc, vec[i].rptr);
      check($sformatf("vec%0d.waddr", i), int'(waddr), int'(vec[i].waddr));
      check($sformatf("vec%0d.wptr", i), int'(wptr), int'(vec[i].wptr));
      check($sformatf("vec%0d.wfull", i), int'(wfull), int'(vec[i].full));
      check($sformatf("vec%0d.walmost_full", i), int'(walmost_full), int'(vec[i].af));
      check($sformatf("vec%0d.wcount", i), int'(wcount), int'(vec[i].cnt));
`ifdef WFULL_OVERFLOW_EN
      if (i >= 8) check($sformatf("vec%0d.wovf", i), int'(wovf), 1);
      else        check($sformatf("vec%0d.wovf", i), int'(wovf), 0);
`endif
    end

    // Wrap: 20 writes with the read pointer trailing the write pointer.
    do_reset("rst_wrap");
    for (int k = 1; k <= 20; k++) begin
      int rk;
      rk = (k >= 3) ? k - 3 : 0;
      apply(1'b1, gray(rk));
      check($sformatf("wrap%0d.waddr", k), int'(waddr), k % 8);
      check($sformatf("wrap%0d.wptr", k), int'(wptr), int'(gray(k)));
      check($sformatf("wrap%0d.wfull", k), int'(wfull), 0);
      check($sformatf("wrap%0d.wcount", k), int'(wcount), k - rk);
    end

    // Reset mid-burst at wcount=5, then first write after release.
    do_reset("rst_pre_burst");
    for (int k = 1; k <= 5; k++) apply(1'b1, 4'b0000);
    check("burst.wcount", int'(wcount), 5);
    check("burst.waddr", int'(waddr), 5);
    do_reset("rst_mid_burst");
    check("post_rst.waddr_before", int'(waddr), 0);
    apply(1'b1, 4'b0000);
    check("post_rst.wptr", int'(wptr), 1);
    check("post_rst.waddr", int'(waddr), 1);
    check("post_rst.wcount", int'(wcount), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wptr_full.md
Name: wptr_full

Overview:
- Write-domain pointer and full-flag logic for the dual-clock async FIFO. Pairs with the read-side pointer/empty block.
- Keeps the binary and Gray write pointers and produces the RAM write address.
- Computes registered full, almost-full and fill-level flags from the read pointer after it has been synchronised into the write domain.
- Sits between the write client, the FIFO RAM write port and the rptr-to-wclk synchroniser.

Parameters:
- WIDTH, 4: pointer width including the wrap bit. Minimum 3. Depth is DEPTH = 2**(WIDTH-1).
- AF_THRESH, 6: almost-full threshold in entries, legal range 1..DEPTH. walmost_full asserts when fill >= AF_THRESH.

Ports:
- wclk  in  1  write-domain clock
- wrst_n  in  1  asynchronous active-low reset
- winc  in  1  write request for this cycle
- wq2_rptr  in  WIDTH  read Gray pointer, already double-synchronised into wclk
- waddr  out  WIDTH-1  RAM write address (binary)
- wptr  out  WIDTH  registered Gray write pointer, sent to the read-domain synchroniser
- wfull  out  1  FIFO full, registered
- walmost_full  out  1  fill >= AF_THRESH, registered
- wcount  out  WIDTH  fill level as seen from the write domain, 0..DEPTH, registered
- wovf  out  1  sticky overflow flag; exists only with WFULL_OVERFLOW_EN

Behaviour:
- One clock (wclk). Reset is asynchronous and active-low (wrst_n).
- While wrst_n is low, all state and outputs are 0: wbin, wptr, waddr, wfull, walmost_full, wcount, wovf.
- Pointer update:
  - wbin_next = wbin + (winc & ~wfull), modulo 2**WIDTH.
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
  - wbin and wptr register wbin_next and wgray_next on posedge wclk.
- waddr = wbin[WIDTH-2:0], combinational from the register. RAM writes at waddr on the same edge when winc & ~wfull.
- Full:
  - wfull_val = (wgray_next == {~wq2_rptr[WIDTH-1:WIDTH-2], wq2_rptr[WIDTH-3:0]}).
  - wfull registers wfull_val, so it asserts on the same edge that accepts the DEPTH-th outstanding write (zero-cycle lag).
- Fill level:
  - rbin = gray2bin(wq2_rptr).
  - wcount registers (wbin_next - rbin), modulo 2**WIDTH.
  - walmost_full registers ((wbin_next - rbin) >= AF_THRESH).
- Write while full: ignored. wbin, wptr and waddr hold; no RAM write is performed.
- Flags are pessimistic. A read advance reaches wq2_rptr after 2 wclk and clears wfull and walmost_full 1 wclk later. The flags never deassert early.
- Simultaneous winc and a wq2_rptr change: both are evaluated in the same next-state equation. The accepted write and the new rptr are both reflected on the next edge.
- Wrap-around: wbin rolls from 2**WIDTH-1 to 0 and waddr rolls from DEPTH-1 to 0. The wrap bit keeps full distinct from empty, and there is no false full at wrap.
- Reset mid-burst: everything clears immediately and asynchronously. Release is synchronous to wclk. The read side must be reset together with it.

Optional Feature:
- Macro: WFULL_OVERFLOW_EN.
- Defined:
  - wovf port is present.
  - wovf sets on the edge after any cycle with winc & wfull.
  - wovf stays set until wrst_n is asserted.
- Undefined:
  - wovf port and its logic are absent.
  - Writes while full are silently dropped.

Decomposition:
- Shared package fifo_pkg holds:
  - default WIDTH
  - DEPTH derivation function
  - bin2gray and gray2bin functions, shared with the read-side block
- Sub-module gray2bin (parameter WIDTH): a purely combinational XOR prefix chain, instantiated once for rbin.

Test Plan (WIDTH=4, AF_THRESH=6):
- Reset: assert wrst_n=0 mid-cycle -> immediately wptr=0, waddr=0, wfull=0, walmost_full=0, wcount=0.
- Fill from empty: wq2_rptr=0, 8 consecutive winc.
  - waddr steps 0..7.
  - wptr steps 1,3,2,6,7,5,4,12.
  - walmost_full=1 after the 6th write.
  - wfull=1 and wcount=8 after the 8th write.
- Write while full: 9th winc -> wptr stays 4'b1100, waddr stays 0. With WFULL_OVERFLOW_EN, wovf=1 on the next edge and stays set.
- Drain one: drive wq2_rptr=4'b0001 -> next edge wfull=0, wcount=7, walmost_full=1. Next winc is accepted, giving wptr=4'b1101 and wfull=1.
- Wrap: stream 20 writes with wq2_rptr tracking wptr two cycles behind.
  - waddr wraps 7->0 twice.
  - wptr wraps 4'b1000 -> 4'b0000.
  - wfull is never asserted.
- Reset mid-burst: wrst_n low at wcount=5 -> all outputs 0 at once. After release, the first winc gives waddr=0 then wptr=1.
